// File: rtl/bvm_pkg.sv
// Shared definitions for the beverage vending controller.
//   state_t       : controller state encoding (IDLE, BREW, DONE)
//   SEL_0..SEL_3  : beverage select codes carried on the request bus
//   T_SELx_DEF    : default brew times in clock cycles per select code
package bvm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BREW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_0 = 2'b00;
  localparam logic [1:0] SEL_1 = 2'b01;
  localparam logic [1:0] SEL_2 = 2'b10;
  localparam logic [1:0] SEL_3 = 2'b11;

  localparam int unsigned T_SEL0_DEF = 4;
  localparam int unsigned T_SEL1_DEF = 6;
  localparam int unsigned T_SEL2_DEF = 8;
  localparam int unsigned T_SEL3_DEF = 10;
  localparam int unsigned CNT_W_DEF  = 4;

endpackage

// File: rtl/bvm_if.sv
// Request/status bus between the front-panel logic and the vending controller.
//   d     : request strobe (rising edge = request)
//   in    : 2-bit beverage select code
//   valid : one-cycle "beverage ready" pulse
//   busy  : request in progress
// master = request source (front panel), slave = vending controller.
interface bvm_if;
  logic       d;
  logic [1:0] in;
  logic       valid;
  logic       busy;

  modport master (output d, output in, input valid, input busy);
  modport slave  (input d, input in, output valid, output busy);
endinterface

// File: rtl/bvm_brew_timer.sv
// Loadable down-counter used to time a brew.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : load i_load_val (has priority over i_dec)
//   i_load_val   : value to load
//   i_dec        : decrement by one
//   o_zero       : count is zero
// The owner only decrements while the count is non-zero, so it never wraps.
module bvm_brew_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/beverage_vending_machine.sv
// Beverage vending controller.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bvm_if.slave -- d/in request from the front panel,
//           valid/busy status to the dispenser and front panel
// A rising edge on d in IDLE accepts a request, latches the select code and
// loads the brew timer with T_SEL[in]-1. BREW runs until the timer reaches
// zero, DONE then pulses valid for one cycle. Accepted at edge k, valid is
// high from edge k+T to edge k+T+1 and busy from edge k to edge k+T+1.
module beverage_vending_machine
  import bvm_pkg::*;
#(
  parameter int unsigned T_SEL0 = T_SEL0_DEF,
  parameter int unsigned T_SEL1 = T_SEL1_DEF,
  parameter int unsigned T_SEL2 = T_SEL2_DEF,
  parameter int unsigned T_SEL3 = T_SEL3_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  bvm_if.slave  bus
);

  state_t           r_state;
  logic             r_d_prev;
  logic [1:0]       r_sel;
  logic             r_valid;
  logic             r_busy;

  logic             w_req;
  logic [1:0]       w_sel;
  logic [CNT_W-1:0] w_load_val;
  logic             w_load;
  logic             w_dec;
  logic             w_zero;

  assign w_req = bus.d & ~r_d_prev;

  // Live code while idle (acceptance cycle), latched code for the rest of
  // the request; the timer only loads in IDLE, so later changes on `in`
  // cannot affect a brew in progress.
  assign w_sel = (r_state == IDLE) ? bus.in : r_sel;

  always_comb begin
    w_load_val = '0;
    case (w_sel)
      SEL_0:   w_load_val = CNT_W'(T_SEL0 - 1);
      SEL_1:   w_load_val = CNT_W'(T_SEL1 - 1);
      SEL_2:   w_load_val = CNT_W'(T_SEL2 - 1);
      default: w_load_val = CNT_W'(T_SEL3 - 1);
    endcase
  end

  assign w_load = (r_state == IDLE) && w_req;
  assign w_dec  = (r_state == BREW) && !w_zero;

  bvm_brew_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_d_prev <= 1'b0;
      r_sel    <= 2'b00;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_d_prev <= bus.d;
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          if (w_req) begin
            r_sel   <= bus.in;
            r_state <= BREW;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        BREW: begin
          r_busy <= 1'b1;
          if (w_zero) begin
            r_state <= DONE;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          // Requests seen on this edge are dropped, not queued.
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid = r_valid;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_beverage_vending_machine.sv
// Directed bench for beverage_vending_machine with default brew times
// (00:4, 01:6, 10:8, 11:10 cycles).
module tb_beverage_vending_machine;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bvm_if bif ();

  beverage_vending_machine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a request that is accepted at the next edge, then measures the
  // latency to valid, the busy length and any activity after completion.
  // pulse_at > 0 fires a second strobe (code 00) that many cycles into the brew.
  task automatic measure(input logic [1:0] sel, input int exp_t, input bit hold,
                         input int pulse_at, input string tag);
    int n;
    int busy_n;
    int extra;
    bif.in = sel;
    bif.d  = 1'b1;
    tick();
    check({tag, "_acc_busy"},  32'(bif.busy),  32'd1);
    check({tag, "_acc_valid"}, 32'(bif.valid), 32'd0);
    if (!hold) bif.d = 1'b0;
    bif.in = ~sel;
    n = 0;
    busy_n = 1;
    while (bif.valid !== 1'b1 && n < 40) begin
      n++;
      if (pulse_at > 0 && n == pulse_at) begin
        bif.d  = 1'b1;
        bif.in = 2'b00;
      end else if (pulse_at > 0 && n == pulse_at + 1) begin
        bif.d = 1'b0;
      end
      tick();
      if (bif.busy === 1'b1) busy_n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_t));
    check({tag, "_busy_at_valid"}, 32'(bif.busy), 32'd1);
    tick();
    check({tag, "_valid_end"}, 32'(bif.valid), 32'd0);
    check({tag, "_busy_end"},  32'(bif.busy),  32'd0);
    check({tag, "_busy_len"},  32'(busy_n),    32'(exp_t + 1));
    extra = 0;
    repeat (15) begin
      tick();
      if (bif.valid === 1'b1 || bif.busy === 1'b1) extra++;
    end
    check({tag, "_no_retrigger"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int extra;
    rst_n  = 1'b0;
    bif.d  = 1'b1;
    bif.in = 2'b00;

    // Reset held with d high: outputs stay low.
    repeat (2) begin
      tick();
      check("rst_valid", 32'(bif.valid), 32'd0);
      check("rst_busy",  32'(bif.busy),  32'd0);
    end
    rst_n = 1'b1;
    // d already high at the first edge after release counts as a request.
    measure(2'b00, 4, 1'b0, 0, "post_rst");

    tick();
    measure(2'b11, 10, 1'b0, 0, "code11");
    measure(2'b00, 4,  1'b0, 0, "code00");
    measure(2'b10, 8,  1'b0, 0, "code10");

    // Strobe with code 00 during a code-11 brew is ignored.
    measure(2'b11, 10, 1'b0, 3, "busy_rej");

    // Held strobe: one request only, then a fresh edge retriggers.
    measure(2'b01, 6, 1'b1, 0, "held");
    bif.d = 1'b0;
    tick();
    measure(2'b01, 6, 1'b0, 0, "rearm");

    // Asynchronous reset three cycles into a code-10 brew.
    bif.in = 2'b10;
    bif.d  = 1'b1;
    tick();
    check("abort_acc_busy", 32'(bif.busy), 32'd1);
    bif.d = 1'b0;
    repeat (3) tick();
    check("abort_pre_busy", 32'(bif.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy_now",  32'(bif.busy),  32'd0);
    check("abort_valid_now", 32'(bif.valid), 32'd0);
    tick();
    rst_n = 1'b1;
    extra = 0;
    repeat (15) begin
      tick();
      if (bif.valid === 1'b1 || bif.busy === 1'b1) extra++;
    end
    check("abort_no_valid", 32'(extra), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
